// File: rtl/mc_rsp_pkg.sv
// Shared encodings for the memory-controller port responder.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: request/response command codes, legal size code, stall slack.
package mc_rsp_pkg;

    // Request commands
    localparam logic [2:0] CMD_RD      = 3'd1;
    localparam logic [2:0] CMD_WR      = 3'd2;

    // Response commands
    localparam logic [2:0] RSP_RD_DATA = 3'd2;
    localparam logic [2:0] RSP_WR_CMP  = 3'd3;

    // Only 8-byte accesses are supported
    localparam logic [1:0] SIZE_8B     = 2'd3;

    // Stall is raised this many entries before the responder is full, giving
    // the requester room to react to the registered stall.
    localparam int         STALL_SLACK = 2;

endpackage

// File: rtl/mc_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
// Latency: push visible at head on the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; head reads 0 when empty.
// Ports: clk/rst_n; push_i/push_dat_i write side; pop_i/pop_dat_o read side;
//        empty_o and count_o (0..DEPTH) report occupancy.
module mc_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (cnt_q != (AW+1)'(DEPTH));
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

    // Head is forced to zero when empty so downstream outputs idle at 0
    assign pop_dat_o = empty_o ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/mc_port_responder.sv
// Memory-controller port responder: 64-bit backing store, fixed-latency ordered responses, flush tracking.
// Latency: response valid LATENCY cycles after request acceptance (plus any response backpressure).
// Backpressure: registered mc_rq_stall at RSP_DEPTH-2 outstanding; requests beyond RSP_DEPTH are dropped (err[0]).
// Ports: mc_rq_* request side, mc_rs_* response side, mc_rq_flush/mc_rs_flush_cmplt flush handshake,
//        err[1:0] sticky {illegal, overflow}. Optional MC_RSP_REQ_CHECK_EN enables illegal-request checking.
module mc_port_responder
    import mc_rsp_pkg::*;
#(
    parameter int RTNCTL_WIDTH = 32,
    parameter int LATENCY      = 4,
    parameter int RSP_DEPTH    = 16,
    parameter int MEM_AW       = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mc_rq_vld,
    input  logic [2:0]              mc_rq_cmd,
    input  logic [47:0]             mc_rq_vadr,
    input  logic [1:0]              mc_rq_size,
    input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
    input  logic [63:0]             mc_rq_data,
    input  logic                    mc_rq_flush,
    output logic                    mc_rq_stall,
    output logic                    mc_rs_vld,
    output logic [2:0]              mc_rs_cmd,
    output logic [63:0]             mc_rs_data,
    output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
    input  logic                    mc_rs_stall,
    output logic                    mc_rs_flush_cmplt,
    output logic [1:0]              err
);

    localparam int RSPW = 3 + 64 + RTNCTL_WIDTH;
    localparam int CW   = $clog2(RSP_DEPTH) + 1;

    logic [63:0]       store_mem [1 << MEM_AW];
    logic [MEM_AW-1:0] idx;

    logic [LATENCY-1:0] pipe_vld_q;
    logic [RSPW-1:0]    pipe_dat_q [LATENCY];

    logic [RSPW-1:0] fifo_dat;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_cnt;

    logic [CW-1:0] outstanding, out_next;
    logic          accept, drop, xfer, illegal, do_wr;
    logic [2:0]    rsp_cmd;
    logic [63:0]   rsp_data;
    logic          wr_acc, wr_xfer;
    logic [CW-1:0] wr_pend_q, wr_pend_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;
    logic          flush_arm_q, flush_arm_d;
    logic          cmplt_q, cmplt_d;
    logic          stall_q;
    logic [1:0]    err_q;
    logic          unused_req;

    assign idx = mc_rq_vadr[3 +: MEM_AW];

`ifdef MC_RSP_REQ_CHECK_EN
    assign illegal = !((mc_rq_cmd == CMD_RD) || (mc_rq_cmd == CMD_WR))
                     || (mc_rq_size != SIZE_8B)
                     || (|(mc_rq_vadr >> (3 + MEM_AW)));
    assign unused_req = ^mc_rq_vadr[2:0];
`else
    assign illegal    = 1'b0;
    assign unused_req = ^{mc_rq_size, mc_rq_vadr};
`endif

    // Outstanding is derived directly from pipeline occupancy and FIFO count
    always_comb begin
        outstanding = fifo_cnt;
        for (int i = 0; i < LATENCY; i++) begin
            outstanding = outstanding + CW'(pipe_vld_q[i]);
        end
    end

    assign accept   = mc_rq_vld && (outstanding < CW'(RSP_DEPTH));
    assign drop     = mc_rq_vld && !accept;
    assign xfer     = mc_rs_vld && !mc_rs_stall;
    assign out_next = outstanding + CW'(accept) - CW'(xfer);

    // Anything that is not a read completes as WR_CMP
    assign rsp_cmd  = (mc_rq_cmd == CMD_RD) ? RSP_RD_DATA : RSP_WR_CMP;
    assign rsp_data = ((mc_rq_cmd == CMD_RD) && !illegal) ? store_mem[idx] : 64'd0;
    assign do_wr    = accept && (mc_rq_cmd == CMD_WR) && !illegal;

    assign wr_acc    = accept && (rsp_cmd == RSP_WR_CMP);
    assign wr_xfer   = xfer && (mc_rs_cmd == RSP_WR_CMP);
    assign wr_pend_d = wr_pend_q + CW'(wr_acc) - CW'(wr_xfer);

    // Responses leave in order, so a flush covers the next wr_pend_d WR_CMPs.
    // A new flush while armed simply re-snapshots, which extends coverage.
    always_comb begin
        flush_arm_d = flush_arm_q;
        flush_cnt_d = flush_cnt_q;
        cmplt_d     = 1'b0;
        if (mc_rq_flush) begin
            flush_cnt_d = wr_pend_d;
        end else if (flush_arm_q) begin
            flush_cnt_d = flush_cnt_q - CW'(wr_xfer);
        end
        if (mc_rq_flush || flush_arm_q) begin
            if (flush_cnt_d == '0) begin
                cmplt_d     = 1'b1;
                flush_arm_d = 1'b0;
            end else begin
                flush_arm_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_dat_q[i] <= '0;
            wr_pend_q   <= '0;
            flush_cnt_q <= '0;
            flush_arm_q <= 1'b0;
            cmplt_q     <= 1'b0;
            stall_q     <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            pipe_vld_q[0] <= accept;
            pipe_dat_q[0] <= {rsp_cmd, rsp_data, mc_rq_rtnctl};
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_dat_q[i] <= pipe_dat_q[i-1];
            end
            wr_pend_q   <= wr_pend_d;
            flush_cnt_q <= flush_cnt_d;
            flush_arm_q <= flush_arm_d;
            cmplt_q     <= cmplt_d;
            stall_q     <= (out_next >= CW'(RSP_DEPTH - STALL_SLACK));
            err_q       <= err_q | {accept && illegal, drop};
        end
    end

    // Backing store is not reset
    always_ff @(posedge clk) begin
        if (do_wr) store_mem[idx] <= mc_rq_data;
    end

    // Pipeline tail pushes unconditionally: accept limit guarantees FIFO room
    mc_rsp_fifo #(
        .WIDTH (RSPW),
        .DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (pipe_vld_q[LATENCY-1]),
        .push_dat_i (pipe_dat_q[LATENCY-1]),
        .pop_i      (xfer),
        .pop_dat_o  (fifo_dat),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    assign mc_rs_vld                              = !fifo_empty;
    assign {mc_rs_cmd, mc_rs_data, mc_rs_rtnctl}  = fifo_dat;
    assign mc_rq_stall                            = stall_q;
    assign mc_rs_flush_cmplt                      = cmplt_q;
    assign err                                    = err_q;

endmodule

// File: tb/tb_mc_port_responder.sv
// Directed bench for mc_port_responder: store/read, stall threshold, overflow drop,
// flush coalescing, mid-flight reset and (with MC_RSP_REQ_CHECK_EN) illegal requests.
// Inputs driven and outputs sampled on the falling edge.
module tb_mc_port_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mc_rq_vld = 1'b0;
    logic [2:0]  mc_rq_cmd = 3'd0;
    logic [47:0] mc_rq_vadr = 48'd0;
    logic [1:0]  mc_rq_size = 2'd3;
    logic [31:0] mc_rq_rtnctl = 32'd0;
    logic [63:0] mc_rq_data = 64'd0;
    logic        mc_rq_flush = 1'b0;
    logic        mc_rq_stall;
    logic        mc_rs_vld;
    logic [2:0]  mc_rs_cmd;
    logic [63:0] mc_rs_data;
    logic [31:0] mc_rs_rtnctl;
    logic        mc_rs_stall = 1'b0;
    logic        mc_rs_flush_cmplt;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;

    mc_port_responder dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mc_rq_vld         (mc_rq_vld),
        .mc_rq_cmd         (mc_rq_cmd),
        .mc_rq_vadr        (mc_rq_vadr),
        .mc_rq_size        (mc_rq_size),
        .mc_rq_rtnctl      (mc_rq_rtnctl),
        .mc_rq_data        (mc_rq_data),
        .mc_rq_flush       (mc_rq_flush),
        .mc_rq_stall       (mc_rq_stall),
        .mc_rs_vld         (mc_rs_vld),
        .mc_rs_cmd         (mc_rs_cmd),
        .mc_rs_data        (mc_rs_data),
        .mc_rs_rtnctl      (mc_rs_rtnctl),
        .mc_rs_stall       (mc_rs_stall),
        .mc_rs_flush_cmplt (mc_rs_flush_cmplt),
        .err               (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rq(input logic [2:0] cmd, input logic [47:0] adr,
                            input logic [63:0] dat, input logic [31:0] tag);
        mc_rq_vld    = 1'b1;
        mc_rq_cmd    = cmd;
        mc_rq_vadr   = adr;
        mc_rq_data   = dat;
        mc_rq_rtnctl = tag;
        mc_rq_size   = 2'd3;
    endtask

    initial begin
        int issued, rise_at, rcv, bad, wrx, third, pulses, pcyc, seen;
        logic got;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk("rst_rq_stall", mc_rq_stall, 0);
        chk("rst_rs_vld", mc_rs_vld, 0);
        chk("rst_rs_cmd", mc_rs_cmd, 0);
        chk("rst_rs_data", mc_rs_data, 0);
        chk("rst_rs_rtnctl", mc_rs_rtnctl, 0);
        chk("rst_flush_cmplt", mc_rs_flush_cmplt, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;

        // ---------------- write then read, latency ----------------
        @(negedge clk); drive_rq(3'd2, 48'h40, 64'hDEADBEEF, 32'd1);
        @(negedge clk); drive_rq(3'd1, 48'h40, 64'd0, 32'd7);
        @(negedge clk); mc_rq_vld = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("lat_not_yet", mc_rs_vld, 0);
        @(negedge clk);
        chk("wr_rsp_vld", mc_rs_vld, 1);
        chk("wr_rsp_cmd", mc_rs_cmd, 3);
        chk("wr_rsp_data", mc_rs_data, 0);
        chk("wr_rsp_tag", mc_rs_rtnctl, 1);
        @(negedge clk);
        chk("rd_rsp_vld", mc_rs_vld, 1);
        chk("rd_rsp_cmd", mc_rs_cmd, 2);
        chk("rd_rsp_data", mc_rs_data, 64'hDEADBEEF);
        chk("rd_rsp_tag", mc_rs_rtnctl, 7);
        @(negedge clk);
        chk("drained", mc_rs_vld, 0);

        // ---------------- stall threshold, requester honours stall ----------------
        issued = 0; rise_at = -1; rcv = 0; bad = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            mc_rs_stall = (cyc < 40);
            if (mc_rs_vld && !mc_rs_stall) begin
                if (mc_rs_rtnctl != 32'(rcv) || mc_rs_cmd != 3'd2) bad++;
                rcv++;
            end
            if (rise_at < 0 && mc_rq_stall) rise_at = issued;
            if (issued < 20 && !mc_rq_stall) begin
                drive_rq(3'd1, 48'(issued * 8), 64'd0, 32'(issued));
                issued++;
            end else begin
                mc_rq_vld = 1'b0;
            end
            if (issued == 20 && rcv == 20) break;
        end
        mc_rq_vld = 1'b0;
        chk("stall_rise_at", rise_at, 14);
        chk("stall_rcv_cnt", rcv, 20);
        chk("stall_order", bad, 0);
        chk("stall_no_overflow", err[0], 0);

        // ---------------- overflow drop: 17 requests, stall ignored ----------------
        @(negedge clk);
        mc_rs_stall = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_rq(3'd1, 48'(i * 8), 64'd0, 32'(100 + i));
            @(negedge clk);
        end
        mc_rq_vld = 1'b0;
        chk("ovf_err0", err[0], 1);
        chk("ovf_rq_stall", mc_rq_stall, 1);
        rcv = 0; bad = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            mc_rs_stall = 1'b0;
            if (mc_rs_vld) begin
                if (mc_rs_rtnctl != 32'(100 + rcv)) bad++;
                rcv++;
            end
            @(negedge clk);
        end
        chk("ovf_rcv_cnt", rcv, 16);
        chk("ovf_order", bad, 0);
        chk("ovf_err_sticky", err[0], 1);

        // ---------------- flush coalescing with toggling response stall ----------------
        wrx = 0; third = -1; pulses = 0; pcyc = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (mc_rs_flush_cmplt) begin pulses++; pcyc = cyc; end
            mc_rs_stall = (cyc % 2 == 1);
            if (mc_rs_vld && !mc_rs_stall && mc_rs_cmd == 3'd3) begin
                wrx++;
                if (wrx == 3) third = cyc;
            end
            if (cyc < 3) drive_rq(3'd2, 48'(32'h100 + cyc * 8), 64'(cyc), 32'(200 + cyc));
            else mc_rq_vld = 1'b0;
            mc_rq_flush = (cyc == 3 || cyc == 5);
        end
        mc_rq_flush = 1'b0; mc_rs_stall = 1'b0;
        chk("flush_wr_cmp_cnt", wrx, 3);
        chk("flush_pulse_cnt", pulses, 1);
        chk("flush_pulse_cyc", pcyc, third + 1);

        // ---------------- flush with nothing pending ----------------
        @(negedge clk); mc_rq_flush = 1'b1;
        @(negedge clk); mc_rq_flush = 1'b0;
        chk("flush_idle_pulse", mc_rs_flush_cmplt, 1);
        @(negedge clk);
        chk("flush_idle_one_cycle", mc_rs_flush_cmplt, 0);

        // ---------------- reset with requests in flight ----------------
        mc_rs_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); drive_rq(3'd1, 48'(i * 8), 64'd0, 32'(300 + i));
        end
        @(negedge clk);
        mc_rq_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rs_vld", mc_rs_vld, 0);
        chk("midrst_rs_tag", mc_rs_rtnctl, 0);
        chk("midrst_rq_stall", mc_rq_stall, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mc_rs_stall = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (mc_rs_vld) seen++;
        end
        chk("midrst_no_rsp", seen, 0);
        chk("midrst_stall_low", mc_rq_stall, 0);
        chk("midrst_err_clr", err, 0);

        // ---------------- read with size=2 ----------------
        @(negedge clk);
        drive_rq(3'd1, 48'h40, 64'd0, 32'd9);
        mc_rq_size = 2'd2;
        @(negedge clk);
        mc_rq_vld = 1'b0;
        mc_rq_size = 2'd3;
        got = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (mc_rs_vld) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("size2_rsp_seen", got, 1);
        chk("size2_rsp_cmd", mc_rs_cmd, 2);
        chk("size2_rsp_tag", mc_rs_rtnctl, 9);
`ifdef MC_RSP_REQ_CHECK_EN
        chk("size2_rsp_data", mc_rs_data, 0);
        chk("size2_err", err, 2'b10);
`else
        chk("size2_rsp_data", mc_rs_data, 64'hDEADBEEF);
        chk("size2_err", err, 2'b00);
`endif
        @(negedge clk);
        chk("size2_drained", mc_rs_vld, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
